// File: rtl/rv32ima_pkg.sv
// Shared types for the load/store unit: access size encoding, command width and exception flags.
package rv32ima_pkg;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} ldst_size_t;

    localparam int LDST_WIDTH_W = 3;

    typedef struct packed {
        logic load_misalign;
        logic store_misalign;
        logic size_fault;
    } ldst_exc_t;

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_DONE} ldst_state_t;

endpackage

// File: rtl/ldst_lane_align.sv
// Combinational byte-lane steering: lane mask, shifted store data over two beats,
// and load extraction with sign/zero extension from the two-beat read buffer.
module ldst_lane_align
    import rv32ima_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [1:0]                size,
    input  logic                      uns,
    input  logic [XLEN-1:0]           wdata,
    input  logic [2*XLEN-1:0]         rbuf,
    output logic [2*(XLEN/8)-1:0]     lane_mask,
    output logic [2*XLEN-1:0]         wdata_shift,
    output logic [XLEN-1:0]           load_data
);
    localparam int NB = XLEN / 8;
    localparam int MW = 2 * NB;

    logic [MW-1:0]   base;
    logic [XLEN-1:0] rshift;
    logic            sign;
    int              nbits;

    always_comb begin
        base = '0;
        case (ldst_size_t'(size))
            SZ_B:    base = MW'(8'h01);
            SZ_H:    base = MW'(8'h03);
            SZ_W:    base = MW'(8'h0F);
            default: base = MW'(8'hFF);
        endcase
        lane_mask   = base << off;
        wdata_shift = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    end

    always_comb begin
        rshift = XLEN'(rbuf >> {off, 3'b000});
        nbits  = 8 << int'(size);
        sign   = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == nbits - 1) sign = rshift[i];
        end
        // Bytes above the access size are filled with the extension bit.
        for (int i = 0; i < XLEN; i++) begin
            load_data[i] = (i < nbits) ? rshift[i] : (~uns & sign);
        end
    end

endmodule

// File: rtl/ldst_unit.sv
// Load/store unit: accepts one access, issues one or two aligned bus beats,
// and holds the result in DONE until the instruction retires.
module ldst_unit
    import rv32ima_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_ren,
    input  logic                    cmd_wen,
    input  logic [LDST_WIDTH_W-1:0] cmd_width,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [XLEN-1:0]         cmd_wdata,
    input  logic                    cmd_retire,
    output logic                    done,
    output logic [XLEN-1:0]         load_data,
    output logic                    load_misalign,
    output logic                    store_misalign,
    output logic                    size_fault,
    output logic                    mem_req,
    output logic                    mem_wen,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [XLEN/8-1:0]       mem_byteen,
    output logic [XLEN-1:0]         mem_wdata,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic                    mem_ready
);
    localparam int NB = XLEN / 8;
    localparam int LG = $clog2(NB);

    ldst_state_t state, state_nxt;
    ldst_exc_t   exc;

    logic              c_load, c_store, c_uns;
    logic [1:0]        c_size;
    logic [ADDR_W-1:0] c_addr;
    logic [XLEN-1:0]   c_wdata;
    logic [2*XLEN-1:0] rbuf;

    logic              accept, in_fault, in_mis, split;
    logic [LG-1:0]     in_off, c_off;
    logic [3:0]        nmask;
    logic [ADDR_W-1:0] beat_addr;
    logic [2*NB-1:0]   lane_mask;
    logic [2*XLEN-1:0] wdata_shift;
    logic [XLEN-1:0]   ext_data;

    assign accept    = (state == S_IDLE) && cmd_valid && (cmd_ren || cmd_wen);
    assign in_off    = cmd_addr[LG-1:0];
    assign in_fault  = int'(cmd_width[1:0]) > LG;
    assign nmask     = (4'd1 << cmd_width[1:0]) - 4'd1;
    assign in_mis    = |(4'(in_off) & nmask);
    assign c_off     = c_addr[LG-1:0];
    assign split     = (int'(c_off) + (1 << int'(c_size))) > NB;
    assign beat_addr = {c_addr[ADDR_W-1:LG], {LG{1'b0}}};

    ldst_lane_align #(.XLEN(XLEN)) u_align (
        .off         (c_off),
        .size        (c_size),
        .uns         (c_uns),
        .wdata       (c_wdata),
        .rbuf        (rbuf),
        .lane_mask   (lane_mask),
        .wdata_shift (wdata_shift),
        .load_data   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (in_fault || (in_mis && MISALIGN_SPLIT == 0)) state_nxt = S_DONE;
                    else                                             state_nxt = S_BEAT0;
                end
            end
            S_BEAT0: if (mem_ready) state_nxt = split ? S_BEAT1 : S_DONE;
            S_BEAT1: if (mem_ready) state_nxt = S_DONE;
            default: if (cmd_retire) state_nxt = S_IDLE;
        endcase
    end

    // Exception flags are control state; cleared on reset and on retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            exc <= '0;
        end else if (accept) begin
            exc.size_fault     <= in_fault;
            exc.load_misalign  <= !in_fault && in_mis && (MISALIGN_SPLIT == 0) && cmd_ren;
            exc.store_misalign <= !in_fault && in_mis && (MISALIGN_SPLIT == 0) && !cmd_ren;
        end else if (state == S_DONE && cmd_retire) begin
            exc <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            c_load  <= cmd_ren;
            c_store <= cmd_wen && !cmd_ren;
            c_uns   <= cmd_width[2];
            c_size  <= cmd_width[1:0];
            c_addr  <= cmd_addr;
            c_wdata <= cmd_wdata;
        end
        if (state == S_BEAT0 && mem_ready) rbuf[XLEN-1:0]      <= mem_rdata;
        if (state == S_BEAT1 && mem_ready) rbuf[2*XLEN-1:XLEN] <= mem_rdata;
    end

    always_comb begin
        cmd_ready      = (state == S_IDLE);
        done           = (state == S_DONE);
        load_misalign  = done && exc.load_misalign;
        store_misalign = done && exc.store_misalign;
        size_fault     = done && exc.size_fault;
        load_data      = (done && c_load && exc == '0) ? ext_data : '0;
        mem_req        = 1'b0;
        mem_wen        = 1'b0;
        mem_addr       = '0;
        mem_byteen     = '0;
        mem_wdata      = '0;
        if (state == S_BEAT0) begin
            mem_req    = 1'b1;
            mem_wen    = c_store;
            mem_addr   = beat_addr;
            mem_byteen = lane_mask[NB-1:0];
            mem_wdata  = wdata_shift[XLEN-1:0];
        end else if (state == S_BEAT1) begin
            mem_req    = 1'b1;
            mem_wen    = c_store;
            mem_addr   = beat_addr + ADDR_W'(NB);
            mem_byteen = lane_mask[2*NB-1:NB];
            mem_wdata  = wdata_shift[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: tb/tb_ldst_unit.sv
// Directed bench for ldst_unit: one split-enabled instance and one exception-mode instance, XLEN = 32.
module tb_ldst_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cmd_valid = 0, cmd_ren = 0, cmd_wen = 0, cmd_retire = 0, mem_ready = 0;
    logic [2:0]  cmd_width = '0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0, mem_rdata = '0;
    logic        cmd_ready, done, load_misalign, store_misalign, size_fault, mem_req, mem_wen;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_byteen;

    logic        b_cmd_valid = 0, b_cmd_ren = 0, b_cmd_wen = 0, b_cmd_retire = 0, b_mem_ready = 0;
    logic [2:0]  b_cmd_width = '0;
    logic [31:0] b_cmd_addr = '0, b_cmd_wdata = '0, b_mem_rdata = '0;
    logic        b_cmd_ready, b_done, b_load_misalign, b_store_misalign, b_size_fault, b_mem_req, b_mem_wen;
    logic [31:0] b_load_data, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_byteen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ldst_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) u_split (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ren(cmd_ren), .cmd_wen(cmd_wen), .cmd_width(cmd_width), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_retire(cmd_retire), .done(done), .load_data(load_data),
        .load_misalign(load_misalign), .store_misalign(store_misalign), .size_fault(size_fault),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    ldst_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) u_nosplit (
        .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_ren(b_cmd_ren), .cmd_wen(b_cmd_wen), .cmd_width(b_cmd_width), .cmd_addr(b_cmd_addr),
        .cmd_wdata(b_cmd_wdata), .cmd_retire(b_cmd_retire), .done(b_done), .load_data(b_load_data),
        .load_misalign(b_load_misalign), .store_misalign(b_store_misalign), .size_fault(b_size_fault),
        .mem_req(b_mem_req), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_byteen(b_mem_byteen),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ren, input logic wen, input logic [2:0] width,
                         input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = 1; cmd_ren = ren; cmd_wen = wen; cmd_width = width;
        cmd_addr = addr; cmd_wdata = wdata;
        step();
        cmd_valid = 0; cmd_ren = 0; cmd_wen = 0;
    endtask

    task automatic beat(input logic [31:0] rdata);
        mem_ready = 1; mem_rdata = rdata;
        step();
        mem_ready = 0;
    endtask

    task automatic retire();
        cmd_retire = 1;
        step();
        cmd_retire = 0;
    endtask

    initial begin
        // Reset
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_load_data", load_data, 0);
        rst = 0;
        step();

        // LW 0x100 with two wait cycles
        issue(1, 0, 3'b010, 32'h100, 0);
        chk("lw_req", mem_req, 1);
        chk("lw_addr", mem_addr, 32'h100);
        chk("lw_byteen", mem_byteen, 4'b1111);
        chk("lw_wen", mem_wen, 0);
        step();
        chk("lw_wait_req", mem_req, 1);
        step();
        chk("lw_wait2_done", done, 0);
        beat(32'hDEADBEEF);
        chk("lw_done", done, 1);
        chk("lw_data", load_data, 32'hDEADBEEF);
        chk("lw_done_req", mem_req, 0);
        cmd_valid = 1; cmd_ren = 1; cmd_width = 3'b010; cmd_addr = 32'h200;
        step(); step(); step();
        chk("lw_hold_done", done, 1);
        chk("lw_hold_ready", cmd_ready, 0);
        chk("lw_hold_req", mem_req, 0);
        chk("lw_hold_data", load_data, 32'hDEADBEEF);
        cmd_valid = 0; cmd_ren = 0;
        retire();
        chk("lw_retired_done", done, 0);
        chk("lw_retired_ready", cmd_ready, 1);
        chk("lw_retired_data", load_data, 0);

        // LB / LBU at 0x103
        issue(1, 0, 3'b000, 32'h103, 0);
        chk("lb_byteen", mem_byteen, 4'b1000);
        chk("lb_addr", mem_addr, 32'h100);
        beat(32'h80000000);
        chk("lb_data", load_data, 32'hFFFFFF80);
        retire();
        issue(1, 0, 3'b100, 32'h103, 0);
        beat(32'h80000000);
        chk("lbu_data", load_data, 32'h00000080);
        retire();

        // SH at 0x102
        issue(0, 1, 3'b001, 32'h102, 32'h1234ABCD);
        chk("sh_wdata", mem_wdata, 32'hABCD0000);
        chk("sh_byteen", mem_byteen, 4'b1100);
        chk("sh_wen", mem_wen, 1);
        beat(0);
        chk("sh_done", done, 1);
        chk("sh_load_data", load_data, 0);
        retire();

        // Misaligned LH inside one word: single beat, no exception
        issue(1, 0, 3'b001, 32'h101, 0);
        chk("lh101_byteen", mem_byteen, 4'b0110);
        beat(32'h00ABCD00);
        chk("lh101_done", done, 1);
        chk("lh101_data", load_data, 32'hFFFFABCD);
        chk("lh101_mis", load_misalign, 0);
        retire();

        // Split LW at 0x102
        issue(1, 0, 3'b010, 32'h102, 0);
        chk("lws_b0_addr", mem_addr, 32'h100);
        chk("lws_b0_byteen", mem_byteen, 4'b1100);
        beat(32'hAAAA0000);
        chk("lws_b1_req", mem_req, 1);
        chk("lws_b1_addr", mem_addr, 32'h104);
        chk("lws_b1_byteen", mem_byteen, 4'b0011);
        chk("lws_b1_done", done, 0);
        beat(32'h0000BBBB);
        chk("lws_done", done, 1);
        chk("lws_data", load_data, 32'hBBBBAAAA);
        chk("lws_mis", load_misalign, 0);
        retire();

        // Same LW on the exception-mode instance
        b_cmd_valid = 1; b_cmd_ren = 1; b_cmd_width = 3'b010; b_cmd_addr = 32'h102;
        step();
        b_cmd_valid = 0; b_cmd_ren = 0;
        chk("lwx_done", b_done, 1);
        chk("lwx_mis", b_load_misalign, 1);
        chk("lwx_req", b_mem_req, 0);
        chk("lwx_data", b_load_data, 0);
        b_cmd_retire = 1;
        step();
        b_cmd_retire = 0;
        chk("lwx_retired", b_load_misalign, 0);

        // Split SW at 0x103
        issue(0, 1, 3'b010, 32'h103, 32'h11223344);
        chk("sws_b0_addr", mem_addr, 32'h100);
        chk("sws_b0_byteen", mem_byteen, 4'b1000);
        chk("sws_b0_wdata", mem_wdata, 32'h44000000);
        chk("sws_b0_wen", mem_wen, 1);
        beat(0);
        chk("sws_b1_addr", mem_addr, 32'h104);
        chk("sws_b1_byteen", mem_byteen, 4'b0111);
        chk("sws_b1_wdata", mem_wdata, 32'h00112233);
        beat(0);
        chk("sws_done", done, 1);
        chk("sws_smis", store_misalign, 0);
        retire();

        // Reset during BEAT1, then a normal access
        issue(1, 0, 3'b010, 32'h102, 0);
        beat(32'h12345678);
        chk("rb1_in_beat1", mem_addr, 32'h104);
        rst = 1;
        step();
        rst = 0;
        chk("rb1_req", mem_req, 0);
        chk("rb1_done", done, 0);
        chk("rb1_ready", cmd_ready, 1);
        issue(1, 0, 3'b001, 32'h106, 0);
        chk("lh106_addr", mem_addr, 32'h104);
        chk("lh106_byteen", mem_byteen, 4'b1100);
        beat(32'h80010000);
        chk("lh106_data", load_data, 32'hFFFF8001);
        retire();

        // SD on XLEN = 32
        issue(1'b0, 1'b1, 3'b011, 32'h100, 32'hFFFFFFFF);
        chk("sd_done", done, 1);
        chk("sd_fault", size_fault, 1);
        chk("sd_req", mem_req, 0);
        chk("sd_smis", store_misalign, 0);
        retire();
        chk("sd_cleared", size_fault, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
